// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART byte stream to image-memory frame loader (optional XOR checksum via CHECKSUM_EN)
module uart_frame_loader #(
  parameter int         IMG_BYTES    = 784,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_dv,
  input  logic [7:0]                   rx_byte,
  output logic                         wr_en,
  output logic [$clog2(IMG_BYTES)-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int AW = $clog2(IMG_BYTES);
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_BYTES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CLKS - 1);

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic {IDLE, LOAD} state_t;
`endif

  state_t        state;
  logic [AW-1:0] count;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
`ifdef CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Inter-byte gap has reached its limit while a frame is in progress
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LIMIT);

  // Frame FSM: sync hunt, pixel writes, optional checksum compare, inter-byte timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      tmo_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      // Gap counter idles at zero and restarts on every received byte
      if (state == IDLE || rx_dv) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      case (state)
        IDLE: begin
          if (rx_dv && rx_byte == SYNC_BYTE) begin
            state <= LOAD;
            count <= '0;
            busy  <= 1'b1;
`ifdef CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end

        LOAD: begin
          if (tmo_hit) begin
            // A byte arriving on the timeout cycle is dropped with the frame
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (rx_dv) begin
            wr_en   <= 1'b1;
            wr_addr <= count;
            wr_data <= rx_byte;
`ifdef CHECKSUM_EN
            csum    <= csum ^ rx_byte;
`endif
            if (count == LAST_ADDR) begin
              // count holds at the last address; it is cleared by the next sync
`ifdef CHECKSUM_EN
              state      <= CHECK;
`else
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              count <= count + AW'(1);
            end
          end
        end

`ifdef CHECKSUM_EN
        CHECK: begin
          if (tmo_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (rx_dv) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_byte == csum) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 784, meaning pixel bytes per frame (28x28 image).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame-start marker byte.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 1_000_000, meaning the maximum clocks allowed between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  meaning the system clock; the block uses this single clock only.
REQ-005 SHALL have port reset  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port rx_dv  input  1  meaning a one-cycle strobe marking rx_byte as valid.
REQ-007 SHALL have port rx_byte  input  8  meaning the received byte.
REQ-008 SHALL have port wr_en  output  1  meaning the image-memory write strobe.
REQ-009 SHALL have port wr_addr  output  $clog2(IMG_BYTES)  meaning the pixel address.
REQ-010 SHALL have port wr_data  output  8  meaning the pixel value.
REQ-011 SHALL have port frame_done  output  1  meaning a one-cycle pulse for a complete, accepted frame.
REQ-012 SHALL have port frame_err  output  1  meaning a one-cycle pulse for an aborted or rejected frame.
REQ-013 SHALL have port busy  output  1  meaning high while the FSM is outside IDLE.

Function
REQ-014 SHALL implement the states IDLE, LOAD and CHECK; CHECK exists only when CHECKSUM_EN is defined.
REQ-015 IDLE: an rx_dv with rx_byte==SYNC_BYTE SHALL move the FSM to LOAD, clear the pixel count and clear the checksum; all other bytes SHALL be silently ignored.
REQ-016 LOAD: each rx_dv SHALL produce exactly one write, with wr_en=1, wr_addr=count and wr_data=rx_byte on the following cycle (latency 1); the count then SHALL increment.
REQ-017 A SYNC_BYTE value received in LOAD SHALL be treated as pixel data, not as a resync.
REQ-018 wr_en SHALL be high for exactly one cycle per pixel and never outside LOAD.
REQ-019 The write of pixel IMG_BYTES-1 SHALL end LOAD: the FSM goes to CHECK when CHECKSUM_EN is defined, otherwise to IDLE with frame_done pulsed in the same cycle as that final wr_en.
REQ-020 wr_addr SHALL never reach IMG_BYTES; the count SHALL NOT wrap within a frame.
REQ-021 A timeout counter SHALL clear on every rx_dv and on entry to LOAD or CHECK.
REQ-022 If the timeout counter reaches TIMEOUT_CLKS-1 while in LOAD or CHECK, the block SHALL pulse frame_err for one cycle, return to IDLE and issue no further writes.
REQ-023 An rx_dv that coincides with the timeout cycle SHALL be ignored.
REQ-024 frame_done and frame_err SHALL never be asserted in the same cycle.
REQ-025 busy SHALL go high on the cycle after the sync byte is accepted and low on the cycle the FSM returns to IDLE.

Reset
REQ-026 On reset the block SHALL set state=IDLE and clear wr_en, wr_addr, wr_data, frame_done, frame_err, busy, the count, the checksum and the timeout counter.
REQ-027 A reset mid-frame SHALL discard the partial frame without pulsing frame_err; memory already written SHALL stay written.

Configuration
REQ-028 The macro CHECKSUM_EN SHALL control frame checksum checking.
REQ-029 With CHECKSUM_EN defined, the checksum SHALL be the running XOR of all pixel bytes.
REQ-030 With CHECKSUM_EN defined, the first rx_dv in CHECK SHALL be compared against the checksum on the following cycle: a match pulses frame_done and a mismatch pulses frame_err, with IDLE entered in either case.
REQ-031 Without CHECKSUM_EN, no checksum logic or CHECK state SHALL exist, and a frame SHALL be exactly SYNC_BYTE followed by IMG_BYTES pixels.

Verification (IMG_BYTES=4, TIMEOUT_CLKS=50)
REQ-032 Nominal, macro off: send A5,01,02,03,04 -> writes (0,01),(1,02),(2,03),(3,04), then frame_done pulses with the addr-3 write.
REQ-033 Garbage before sync: send 11,22,A5,AA,BB,CC,DD -> no writes before the sync; then addr0..3 = AA,BB,CC,DD and one frame_done.
REQ-034 Checksum, macro on: send A5,01,02,04,08 followed by 0F -> frame_done; repeat with 0E as the last byte -> frame_err, no frame_done.
REQ-035 Timeout: send A5,01,02 and then idle for 60 clocks -> exactly one frame_err, busy low, no third write; a following complete frame loads normally.
REQ-036 Reset mid-frame: send A5,01 and assert reset for 1 cycle -> all outputs 0, no pulse; send A5,09,08,07,06 -> addresses restart at 0.
REQ-037 Data equal to sync: send A5,A5,A5,A5,A5 -> four writes of A5 at addr 0..3 and frame_done (macro off).
